// File: rtl/conv_ctrl_param.sv
// Parametrised convolution-engine sequencer: loads filter/slice rows, walks MAC windows, packs results.
// Latency: one state per cycle; memory states dwell until mem_rdy, compute states run fixed cycle counts.
// Backpressure: mem_rdy=0 holds LD_FILTER/LD_SLICE/WRITE_MEM with all indices frozen; abort drops to IDLE.
module conv_ctrl_param #(
   parameter int FILT_ROWS    = 4,
   parameter int SLICE_ROWS   = 16,
   parameter int MAC_STEPS    = 16,
   parameter int COL_STEPS    = 13,
   parameter int OUT_PER_WORD = 4,
   parameter int NUM_OUT      = 43,
   parameter int NUM_FILTERS  = 1,
   localparam int FR_W = (FILT_ROWS    > 1) ? $clog2(FILT_ROWS)    : 1,
   localparam int SR_W = (SLICE_ROWS   > 1) ? $clog2(SLICE_ROWS)   : 1,
   localparam int MS_W = (MAC_STEPS    > 1) ? $clog2(MAC_STEPS)    : 1,
   localparam int CS_W = (COL_STEPS    > 1) ? $clog2(COL_STEPS)    : 1,
   localparam int OW_W = (OUT_PER_WORD > 1) ? $clog2(OUT_PER_WORD) : 1,
   localparam int NO_W = (NUM_OUT      > 1) ? $clog2(NUM_OUT)      : 1,
   localparam int NF_W = (NUM_FILTERS  > 1) ? $clog2(NUM_FILTERS)  : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            mem_rdy,
   output logic            busy,
   output logic            done,
   output logic [3:0]      state,
   output logic            offset_ld,
   output logic            offset_inc,
   output logic [1:0]      mem_adr_sel,
   output logic            filt_wr_en,
   output logic [FR_W-1:0] filt_row,
   output logic            slice_wr_en,
   output logic [SR_W-1:0] slice_row,
   output logic            buf_ld_en,
   output logic [FR_W-1:0] buf_row,
   output logic            mac_en,
   output logic            acc_clr,
   output logic            res_ld,
   output logic [OW_W-1:0] res_slot,
   output logic            mem_wr_en,
   output logic [CS_W-1:0] col_idx,
   output logic [NO_W-1:0] out_idx,
   output logic [NF_W-1:0] filt_idx
);

   localparam logic [3:0] S_IDLE        = 4'd0;
   localparam logic [3:0] S_INIT        = 4'd1;
   localparam logic [3:0] S_LD_FILTER   = 4'd2;
   localparam logic [3:0] S_LD_SLICE    = 4'd3;
   localparam logic [3:0] S_LD_BUFFER   = 4'd4;
   localparam logic [3:0] S_MAC         = 4'd5;
   localparam logic [3:0] S_LD_RESULT   = 4'd6;
   localparam logic [3:0] S_WRITE_MEM   = 4'd7;
   localparam logic [3:0] S_UPDATE      = 4'd8;
   localparam logic [3:0] S_INC_OFFSET  = 4'd9;
   localparam logic [3:0] S_NEXT_FILTER = 4'd10;
   localparam logic [3:0] S_DONE        = 4'd11;

   localparam logic [FR_W-1:0] FR_LAST = FR_W'(FILT_ROWS - 1);
   localparam logic [SR_W-1:0] SR_LAST = SR_W'(SLICE_ROWS - 1);
   localparam logic [MS_W-1:0] MS_LAST = MS_W'(MAC_STEPS - 1);
   localparam logic [CS_W-1:0] CS_LAST = CS_W'(COL_STEPS - 1);
   localparam logic [OW_W-1:0] OW_LAST = OW_W'(OUT_PER_WORD - 1);
   localparam logic [NO_W-1:0] NO_LAST = NO_W'(NUM_OUT - 1);
   localparam logic [NF_W-1:0] NF_LAST = NF_W'(NUM_FILTERS - 1);

   // MAC cycle counter is internal; the datapath only sees mac_en
   logic [MS_W-1:0] mac_cnt;

   // Sequencer state and loop counters; abort and reset both return everything to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         filt_row  <= '0;
         slice_row <= '0;
         buf_row   <= '0;
         mac_cnt   <= '0;
         res_slot  <= '0;
         out_idx   <= '0;
         col_idx   <= '0;
         filt_idx  <= '0;
      end else if (abort && (state != S_IDLE)) begin
         state     <= S_IDLE;
         filt_row  <= '0;
         slice_row <= '0;
         buf_row   <= '0;
         mac_cnt   <= '0;
         res_slot  <= '0;
         out_idx   <= '0;
         col_idx   <= '0;
         filt_idx  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_INIT;
            end
            S_INIT: begin
               // start is a level: hold here until the requester lets go
               filt_row  <= '0;
               slice_row <= '0;
               buf_row   <= '0;
               mac_cnt   <= '0;
               res_slot  <= '0;
               out_idx   <= '0;
               col_idx   <= '0;
               filt_idx  <= '0;
               if (!start) state <= S_LD_FILTER;
            end
            S_LD_FILTER: begin
               if (mem_rdy) begin
                  if (filt_row == FR_LAST) begin
                     filt_row <= '0;
                     state    <= S_LD_SLICE;
                  end else begin
                     filt_row <= filt_row + FR_W'(1);
                  end
               end
            end
            S_LD_SLICE: begin
               if (mem_rdy) begin
                  if (slice_row == SR_LAST) begin
                     slice_row <= '0;
                     state     <= S_LD_BUFFER;
                  end else begin
                     slice_row <= slice_row + SR_W'(1);
                  end
               end
            end
            S_LD_BUFFER: begin
               if (buf_row == FR_LAST) begin
                  buf_row <= '0;
                  state   <= S_MAC;
               end else begin
                  buf_row <= buf_row + FR_W'(1);
               end
            end
            S_MAC: begin
               if (mac_cnt == MS_LAST) begin
                  mac_cnt <= '0;
                  state   <= S_LD_RESULT;
               end else begin
                  mac_cnt <= mac_cnt + MS_W'(1);
               end
            end
            S_LD_RESULT: begin
               // a full word or the filter's final result forces a write; otherwise keep packing
               if ((res_slot == OW_LAST) || (out_idx == NO_LAST)) begin
                  state <= S_WRITE_MEM;
               end else begin
                  res_slot <= res_slot + OW_W'(1);
                  out_idx  <= out_idx + NO_W'(1);
                  state    <= S_UPDATE;
               end
            end
            S_WRITE_MEM: begin
               if (mem_rdy) begin
                  res_slot <= '0;
                  if (out_idx == NO_LAST) begin
                     state <= S_NEXT_FILTER;
                  end else begin
                     out_idx <= out_idx + NO_W'(1);
                     state   <= S_UPDATE;
                  end
               end
            end
            S_UPDATE: begin
               if (col_idx == CS_LAST) begin
                  col_idx <= '0;
                  state   <= S_INC_OFFSET;
               end else begin
                  col_idx <= col_idx + CS_W'(1);
                  state   <= S_LD_BUFFER;
               end
            end
            S_INC_OFFSET: begin
               slice_row <= '0;
               state     <= S_LD_SLICE;
            end
            S_NEXT_FILTER: begin
               if (filt_idx == NF_LAST) begin
                  state <= S_DONE;
               end else begin
                  filt_idx  <= filt_idx + NF_W'(1);
                  filt_row  <= '0;
                  slice_row <= '0;
                  buf_row   <= '0;
                  mac_cnt   <= '0;
                  res_slot  <= '0;
                  out_idx   <= '0;
                  col_idx   <= '0;
                  state     <= S_LD_FILTER;
               end
            end
            S_DONE: begin
               // leave IDLE showing clean indices for the next run
               filt_row  <= '0;
               slice_row <= '0;
               buf_row   <= '0;
               mac_cnt   <= '0;
               res_slot  <= '0;
               out_idx   <= '0;
               col_idx   <= '0;
               filt_idx  <= '0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Moore decode of state and counters; memory strobes additionally qualified by mem_rdy
   always_comb begin
      busy        = (state != S_IDLE);
      done        = (state == S_DONE);
      offset_ld   = (state == S_INIT) ||
                    ((state == S_NEXT_FILTER) && (filt_idx != NF_LAST));
      offset_inc  = (state == S_INC_OFFSET);
      filt_wr_en  = (state == S_LD_FILTER) && mem_rdy;
      slice_wr_en = (state == S_LD_SLICE) && mem_rdy;
      buf_ld_en   = (state == S_LD_BUFFER);
      mac_en      = (state == S_MAC);
      acc_clr     = (state == S_LD_RESULT);
      res_ld      = (state == S_LD_RESULT);
      mem_wr_en   = (state == S_WRITE_MEM) && mem_rdy;
      mem_adr_sel = 2'd0;
      case (state)
         S_LD_SLICE:  mem_adr_sel = 2'd1;
         S_WRITE_MEM: mem_adr_sel = 2'd2;
         default:     mem_adr_sel = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_conv_ctrl_param.sv
// Self-checking bench for conv_ctrl_param: small, default and three-filter configurations.
// Latency checked against cycle counts from LD_FILTER entry; writes/results tracked through queues.
// Backpressure exercised by dropping mem_rdy in LD_SLICE and WRITE_MEM.
module tb_conv_ctrl_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   // small configuration (2,3,2,2,2,3,1)
   logic       s_start = 1'b0, s_abort = 1'b0, s_mem_rdy = 1'b1;
   logic       s_busy, s_done, s_offset_ld, s_offset_inc, s_filt_wr_en, s_slice_wr_en;
   logic       s_buf_ld_en, s_mac_en, s_acc_clr, s_res_ld, s_mem_wr_en;
   logic [3:0] s_state;
   logic [1:0] s_mem_adr_sel, s_slice_row, s_out_idx;
   logic [0:0] s_filt_row, s_buf_row, s_res_slot, s_col_idx, s_filt_idx;

   // default configuration
   logic       d_start = 1'b0, d_abort = 1'b0, d_mem_rdy = 1'b1;
   logic       d_busy, d_done, d_offset_ld, d_offset_inc, d_filt_wr_en, d_slice_wr_en;
   logic       d_buf_ld_en, d_mac_en, d_acc_clr, d_res_ld, d_mem_wr_en;
   logic [3:0] d_state, d_slice_row, d_col_idx;
   logic [1:0] d_mem_adr_sel, d_filt_row, d_buf_row, d_res_slot;
   logic [5:0] d_out_idx;
   logic [0:0] d_filt_idx;

   // small configuration with three filters
   logic       t_start = 1'b0, t_abort = 1'b0, t_mem_rdy = 1'b1;
   logic       t_busy, t_done, t_offset_ld, t_offset_inc, t_filt_wr_en, t_slice_wr_en;
   logic       t_buf_ld_en, t_mac_en, t_acc_clr, t_res_ld, t_mem_wr_en;
   logic [3:0] t_state;
   logic [1:0] t_mem_adr_sel, t_slice_row, t_out_idx, t_filt_idx;
   logic [0:0] t_filt_row, t_buf_row, t_res_slot, t_col_idx;

   conv_ctrl_param #(.FILT_ROWS(2), .SLICE_ROWS(3), .MAC_STEPS(2), .COL_STEPS(2),
                     .OUT_PER_WORD(2), .NUM_OUT(3), .NUM_FILTERS(1)) u_s (
      .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .mem_rdy(s_mem_rdy),
      .busy(s_busy), .done(s_done), .state(s_state), .offset_ld(s_offset_ld),
      .offset_inc(s_offset_inc), .mem_adr_sel(s_mem_adr_sel), .filt_wr_en(s_filt_wr_en),
      .filt_row(s_filt_row), .slice_wr_en(s_slice_wr_en), .slice_row(s_slice_row),
      .buf_ld_en(s_buf_ld_en), .buf_row(s_buf_row), .mac_en(s_mac_en), .acc_clr(s_acc_clr),
      .res_ld(s_res_ld), .res_slot(s_res_slot), .mem_wr_en(s_mem_wr_en), .col_idx(s_col_idx),
      .out_idx(s_out_idx), .filt_idx(s_filt_idx));

   conv_ctrl_param u_d (
      .clk(clk), .rst(rst), .start(d_start), .abort(d_abort), .mem_rdy(d_mem_rdy),
      .busy(d_busy), .done(d_done), .state(d_state), .offset_ld(d_offset_ld),
      .offset_inc(d_offset_inc), .mem_adr_sel(d_mem_adr_sel), .filt_wr_en(d_filt_wr_en),
      .filt_row(d_filt_row), .slice_wr_en(d_slice_wr_en), .slice_row(d_slice_row),
      .buf_ld_en(d_buf_ld_en), .buf_row(d_buf_row), .mac_en(d_mac_en), .acc_clr(d_acc_clr),
      .res_ld(d_res_ld), .res_slot(d_res_slot), .mem_wr_en(d_mem_wr_en), .col_idx(d_col_idx),
      .out_idx(d_out_idx), .filt_idx(d_filt_idx));

   conv_ctrl_param #(.FILT_ROWS(2), .SLICE_ROWS(3), .MAC_STEPS(2), .COL_STEPS(2),
                     .OUT_PER_WORD(2), .NUM_OUT(3), .NUM_FILTERS(3)) u_t (
      .clk(clk), .rst(rst), .start(t_start), .abort(t_abort), .mem_rdy(t_mem_rdy),
      .busy(t_busy), .done(t_done), .state(t_state), .offset_ld(t_offset_ld),
      .offset_inc(t_offset_inc), .mem_adr_sel(t_mem_adr_sel), .filt_wr_en(t_filt_wr_en),
      .filt_row(t_filt_row), .slice_wr_en(t_slice_wr_en), .slice_row(t_slice_row),
      .buf_ld_en(t_buf_ld_en), .buf_row(t_buf_row), .mac_en(t_mac_en), .acc_clr(t_acc_clr),
      .res_ld(t_res_ld), .res_slot(t_res_slot), .mem_wr_en(t_mem_wr_en), .col_idx(t_col_idx),
      .out_idx(t_out_idx), .filt_idx(t_filt_idx));

   // reset is applied while this runs; every observable output must be zero
   task automatic test_reset();
      logic [31:0] s_all;
      s_all = {s_busy, s_done, s_state, s_offset_ld, s_offset_inc, s_mem_adr_sel, s_filt_wr_en,
               s_filt_row, s_slice_wr_en, s_slice_row, s_buf_ld_en, s_buf_row, s_mac_en,
               s_acc_clr, s_res_ld, s_res_slot, s_mem_wr_en, s_col_idx, s_out_idx, s_filt_idx};
      n_tests++;
      if (s_all !== 32'd0) begin n_fail++; $display("FAIL reset_small outputs=%h want 0", s_all); end
      n_tests++;
      if ({d_busy, d_state, d_out_idx, d_col_idx, d_slice_row} !== 19'd0) begin
         n_fail++; $display("FAIL reset_default busy=%b state=%0d out=%0d want 0", d_busy, d_state, d_out_idx);
      end
      n_tests++;
      if ({t_busy, t_state, t_filt_idx, t_offset_ld} !== 8'd0) begin
         n_fail++; $display("FAIL reset_multi busy=%b state=%0d filt=%0d want 0", t_busy, t_state, t_filt_idx);
      end
   endtask

   // small config, no stalls: done lands on cycle 30 counting LD_FILTER entry as cycle 1
   task automatic test_small_timing();
      int sb[$];
      int c, exp;
      bit got_done;
      sb.push_back(1*16 + 1);
      sb.push_back(2*16 + 0);
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      c = 0; got_done = 1'b0;
      for (int i = 0; i < 200 && !got_done; i++) begin
         @(negedge clk);
         if (c == 0 && s_filt_wr_en) c = 1; else if (c > 0) c++;
         if (s_mem_wr_en) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL small_wr_extra out_idx=%0d slot=%0d want no write", s_out_idx, s_res_slot);
            end else begin
               exp = sb.pop_front();
               if (int'(s_out_idx)*16 + int'(s_res_slot) !== exp) begin
                  n_fail++; $display("FAIL small_wr out_idx=%0d slot=%0d want %0d/%0d", s_out_idx, s_res_slot, exp/16, exp%16);
               end
            end
         end
         if (s_done) begin
            got_done = 1'b1;
            n_tests++;
            if (c !== 30) begin n_fail++; $display("FAIL small_done_cycle got %0d want 30", c); end
         end
      end
      n_tests++;
      if (!got_done) begin n_fail++; $display("FAIL small_timeout no done within budget"); end
      n_tests++;
      if (sb.size() !== 0) begin n_fail++; $display("FAIL small_wr_count missing %0d writes", sb.size()); end
   endtask

   // five stalled cycles in LD_SLICE and in WRITE_MEM delay done by exactly ten cycles
   task automatic test_stall();
      int sb[$];
      int c, exp, st;
      bit got_done, d1, d2;
      logic [1:0] held_row, held_out;
      sb.push_back(1*16 + 1);
      sb.push_back(2*16 + 0);
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      c = 0; st = 0; got_done = 1'b0; d1 = 1'b0; d2 = 1'b0;
      held_row = '0; held_out = '0;
      for (int i = 0; i < 200 && !got_done; i++) begin
         @(negedge clk);
         if (!d1 && s_mem_adr_sel == 2'd1) begin d1 = 1'b1; st = 5; held_row = s_slice_row; end
         if (!d2 && s_mem_adr_sel == 2'd2) begin d2 = 1'b1; st = 5; held_out = s_out_idx; end
         s_mem_rdy = (st > 0) ? 1'b0 : 1'b1;
         #1;
         if (st > 0) begin
            st--;
            n_tests++;
            if (s_mem_adr_sel == 2'd1 && (s_slice_row !== held_row || s_slice_wr_en !== 1'b0)) begin
               n_fail++; $display("FAIL stall_slice row=%0d wr=%b want row %0d wr 0", s_slice_row, s_slice_wr_en, held_row);
            end else if (s_mem_adr_sel == 2'd2 && (s_out_idx !== held_out || s_mem_wr_en !== 1'b0)) begin
               n_fail++; $display("FAIL stall_write out=%0d wr=%b want out %0d wr 0", s_out_idx, s_mem_wr_en, held_out);
            end
         end
         if (c == 0 && s_busy && !s_offset_ld) c = 1; else if (c > 0) c++;
         if (s_mem_wr_en) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL stall_wr_extra out_idx=%0d want no write", s_out_idx);
            end else begin
               exp = sb.pop_front();
               if (int'(s_out_idx)*16 + int'(s_res_slot) !== exp) begin
                  n_fail++; $display("FAIL stall_wr out_idx=%0d slot=%0d want %0d/%0d", s_out_idx, s_res_slot, exp/16, exp%16);
               end
            end
         end
         if (s_done) begin
            got_done = 1'b1;
            n_tests++;
            if (c !== 40) begin n_fail++; $display("FAIL stall_done_cycle got %0d want 40", c); end
         end
      end
      s_mem_rdy = 1'b1;
      n_tests++;
      if (!got_done || sb.size() !== 0) begin
         n_fail++; $display("FAIL stall_complete done=%b pending=%0d want 1/0", got_done, sb.size());
      end
   endtask

   // default parameters: 43 results, 11 packed writes, offset advances after windows 13/26/39
   task automatic test_defaults();
      int wq[$];
      int rq[$];
      int exp, n_inc, n_done;
      bit got_done;
      for (int k = 0; k < 43; k++) rq.push_back(k*16 + (k % 4));
      for (int k = 0; k < 10; k++) wq.push_back((4*k + 3)*16 + 3);
      wq.push_back(42*16 + 2);
      @(negedge clk); d_start = 1'b1;
      @(negedge clk); d_start = 1'b0;
      n_inc = 0; n_done = 0; got_done = 1'b0;
      for (int i = 0; i < 3000 && !got_done; i++) begin
         @(negedge clk);
         if (d_res_ld) begin
            n_tests++;
            if (rq.size() == 0) begin
               n_fail++; $display("FAIL dflt_res_extra out_idx=%0d want none", d_out_idx);
            end else begin
               exp = rq.pop_front();
               if (int'(d_out_idx)*16 + int'(d_res_slot) !== exp) begin
                  n_fail++; $display("FAIL dflt_res out=%0d slot=%0d want %0d/%0d", d_out_idx, d_res_slot, exp/16, exp%16);
               end
            end
         end
         if (d_mem_wr_en) begin
            n_tests++;
            if (wq.size() == 0) begin
               n_fail++; $display("FAIL dflt_wr_extra out_idx=%0d want none", d_out_idx);
            end else begin
               exp = wq.pop_front();
               if (int'(d_out_idx)*16 + int'(d_res_slot) !== exp) begin
                  n_fail++; $display("FAIL dflt_wr out=%0d slot=%0d want %0d/%0d", d_out_idx, d_res_slot, exp/16, exp%16);
               end
            end
         end
         if (d_offset_inc) n_inc++;
         if (d_done) begin got_done = 1'b1; n_done++; end
      end
      repeat (5) begin @(negedge clk); if (d_done) n_done++; end
      n_tests++;
      if (rq.size() !== 0 || wq.size() !== 0) begin
         n_fail++; $display("FAIL dflt_counts missing res=%0d wr=%0d want 0/0", rq.size(), wq.size());
      end
      n_tests++;
      if (n_inc !== 3) begin n_fail++; $display("FAIL dflt_offset_inc got %0d want 3", n_inc); end
      n_tests++;
      if (n_done !== 1) begin n_fail++; $display("FAIL dflt_done got %0d want 1", n_done); end
   endtask

   // three filters: offset reloads at INIT and twice in NEXT_FILTER; a stray start mid-run is ignored
   task automatic test_multi_filter();
      int fq[$];
      int wq[$];
      int exp, n_ld, n_done;
      bit got_done;
      for (int f = 0; f < 3; f++) begin
         fq.push_back(f);
         wq.push_back(1*16 + 1);
         wq.push_back(2*16 + 0);
      end
      @(negedge clk); t_start = 1'b1;
      @(negedge clk); t_start = 1'b0;
      n_ld = 1; n_done = 0; got_done = 1'b0;
      for (int i = 0; i < 400 && !got_done; i++) begin
         @(negedge clk);
         t_start = (i == 40) ? 1'b1 : 1'b0;
         if (t_offset_ld) n_ld++;
         if (t_filt_wr_en && t_filt_row == 1'b0) begin
            n_tests++;
            if (fq.size() == 0) begin
               n_fail++; $display("FAIL multi_filt_extra filt_idx=%0d want none", t_filt_idx);
            end else begin
               exp = fq.pop_front();
               if (int'(t_filt_idx) !== exp) begin
                  n_fail++; $display("FAIL multi_filt_idx got %0d want %0d", t_filt_idx, exp);
               end
            end
         end
         if (t_mem_wr_en) begin
            n_tests++;
            if (wq.size() == 0) begin
               n_fail++; $display("FAIL multi_wr_extra out_idx=%0d want none", t_out_idx);
            end else begin
               exp = wq.pop_front();
               if (int'(t_out_idx)*16 + int'(t_res_slot) !== exp) begin
                  n_fail++; $display("FAIL multi_wr out=%0d slot=%0d want %0d/%0d", t_out_idx, t_res_slot, exp/16, exp%16);
               end
            end
         end
         if (t_done) begin got_done = 1'b1; n_done++; end
      end
      t_start = 1'b0;
      repeat (5) begin @(negedge clk); if (t_done) n_done++; end
      n_tests++;
      if (n_ld !== 3) begin n_fail++; $display("FAIL multi_offset_ld got %0d want 3", n_ld); end
      n_tests++;
      if (fq.size() !== 0 || wq.size() !== 0 || n_done !== 1) begin
         n_fail++; $display("FAIL multi_counts filt_left=%0d wr_left=%0d done=%0d want 0/0/1", fq.size(), wq.size(), n_done);
      end
   endtask

   // abort in MAC clears everything without done; the following run is complete and on time
   task automatic test_abort();
      int c, n_wr, n_done;
      bit hit, got_done;
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (s_mac_en && s_col_idx == 1'b1) hit = 1'b1;
      end
      n_tests++;
      if (!hit) begin n_fail++; $display("FAIL abort_reach_mac timeout want mac_en"); end
      s_abort = 1'b1;
      @(negedge clk);
      s_abort = 1'b0;
      n_tests++;
      if ({s_busy, s_done, s_state, s_out_idx, s_col_idx, s_slice_row, s_filt_row, s_buf_row, s_res_slot, s_filt_idx} !== 15'd0) begin
         n_fail++; $display("FAIL abort_clear busy=%b state=%0d col=%0d slice=%0d want 0", s_busy, s_state, s_col_idx, s_slice_row);
      end
      n_done = 0;
      s_abort = 1'b1;
      repeat (3) begin @(negedge clk); if (s_done || s_busy) n_done++; end
      s_abort = 1'b0;
      n_tests++;
      if (n_done !== 0) begin n_fail++; $display("FAIL abort_idle got %0d active cycles want 0", n_done); end
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      c = 0; n_wr = 0; got_done = 1'b0;
      for (int i = 0; i < 200 && !got_done; i++) begin
         @(negedge clk);
         if (c == 0 && s_filt_wr_en) c = 1; else if (c > 0) c++;
         if (s_mem_wr_en) n_wr++;
         if (s_done) got_done = 1'b1;
      end
      n_tests++;
      if (!got_done || c !== 30 || n_wr !== 2) begin
         n_fail++; $display("FAIL abort_rerun done=%b cycle=%0d writes=%0d want 1/30/2", got_done, c, n_wr);
      end
   endtask

   // asynchronous reset between edges in WRITE_MEM; with start held the sequencer parks in INIT
   task automatic test_rst_mid();
      bit hit, got_done;
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (s_mem_adr_sel == 2'd2) hit = 1'b1;
      end
      n_tests++;
      if (!hit) begin n_fail++; $display("FAIL rst_reach_write timeout want WRITE_MEM"); end
      #2;
      rst = 1'b1;
      s_start = 1'b1;
      #1;
      n_tests++;
      if ({s_busy, s_state, s_mem_wr_en, s_mem_adr_sel, s_out_idx, s_res_slot, s_col_idx} !== 12'd0) begin
         n_fail++; $display("FAIL rst_async busy=%b state=%0d wr=%b sel=%0d out=%0d want 0", s_busy, s_state, s_mem_wr_en, s_mem_adr_sel, s_out_idx);
      end
      @(negedge clk); rst = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (s_busy !== 1'b1 || s_offset_ld !== 1'b1 || s_filt_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL rst_hold_init busy=%b offset_ld=%b filt_wr=%b want 1/1/0", s_busy, s_offset_ld, s_filt_wr_en);
      end
      s_start = 1'b0;
      got_done = 1'b0;
      for (int i = 0; i < 200 && !got_done; i++) begin
         @(negedge clk);
         if (s_done) got_done = 1'b1;
      end
      n_tests++;
      if (!got_done) begin n_fail++; $display("FAIL rst_recover no done within budget"); end
   endtask

   initial begin
      rst = 1'b1;
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_small_timing();
      test_stall();
      test_defaults();
      test_multi_filter();
      test_abort();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
